// File: rtl/hyperbus_port_arbiter.sv
// hyperbus_port_arbiter: round-robin N-port front end holding the grant per transaction.
// Optional watchdog abort is built when HYPERBUS_ARB_WATCHDOG_EN is defined.
module hyperbus_port_arbiter #(
  parameter int NumPorts   = 2,
  parameter int TransWidth = 48,
  parameter int DataWidth  = 32,
  parameter int StrbWidth  = 4,
  parameter int WdogCycles = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts*TransWidth-1:0]  port_trans_i,
  input  logic [NumPorts-1:0]             port_write_i,
  input  logic [NumPorts-1:0]             port_trans_valid_i,
  output logic [NumPorts-1:0]             port_trans_ready_o,
  input  logic [NumPorts*DataWidth-1:0]   port_tx_data_i,
  input  logic [NumPorts*StrbWidth-1:0]   port_tx_strb_i,
  input  logic [NumPorts-1:0]             port_tx_last_i,
  input  logic [NumPorts-1:0]             port_tx_valid_i,
  output logic [NumPorts-1:0]             port_tx_ready_o,
  output logic [DataWidth-1:0]            port_rx_data_o,
  output logic                            port_rx_last_o,
  output logic                            port_rx_error_o,
  output logic [NumPorts-1:0]             port_rx_valid_o,
  input  logic [NumPorts-1:0]             port_rx_ready_i,
  output logic                            port_b_error_o,
  output logic [NumPorts-1:0]             port_b_valid_o,
  input  logic [NumPorts-1:0]             port_b_ready_i,
  output logic [TransWidth-1:0]           trans_o,
  output logic                            trans_write_o,
  output logic                            trans_valid_o,
  input  logic                            trans_ready_i,
  output logic [DataWidth-1:0]            tx_data_o,
  output logic [StrbWidth-1:0]            tx_strb_o,
  output logic                            tx_last_o,
  output logic                            tx_valid_o,
  input  logic                            tx_ready_i,
  input  logic [DataWidth-1:0]            rx_data_i,
  input  logic                            rx_last_i,
  input  logic                            rx_error_i,
  input  logic                            rx_valid_i,
  output logic                            rx_ready_o,
  input  logic                            b_error_i,
  input  logic                            b_valid_i,
  output logic                            b_ready_o,
`ifdef HYPERBUS_ARB_WATCHDOG_EN
  output logic                            wdog_fired_o,
`endif
  output logic                            busy_o,
  output logic [$clog2(NumPorts)-1:0]     grant_o
);

  localparam int GW = $clog2(NumPorts);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WDATA, S_WRESP, S_RDATA, S_ABRT_R, S_DRAIN, S_ABRT_B
  } state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic          write_q, write_d;
  logic [GW-1:0] sel;
  logic [GW-1:0] rr_next;
  logic          req;
  int            idx;
  int            gi;
  logic          trans_hs, tx_hs, rx_hs, b_hs;

  assign gi      = int'(grant_q);
  assign rr_next = (gi == NumPorts - 1) ? '0 : grant_q + GW'(1);

  assign trans_hs = (state_q == S_ISSUE) && port_trans_valid_i[gi] && trans_ready_i;
  assign tx_hs    = (state_q == S_WDATA) && port_tx_valid_i[gi] && tx_ready_i;
  assign rx_hs    = (state_q == S_RDATA) && rx_valid_i && port_rx_ready_i[gi];
  assign b_hs     = (state_q == S_WRESP) && b_valid_i && port_b_ready_i[gi];

  // Descending scan: the last hit is the nearest requester at/after rr_q.
  always_comb begin
    sel = rr_q;
    req = 1'b0;
    idx = 0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= NumPorts) idx = idx - NumPorts;
      if (port_trans_valid_i[idx]) begin
        sel = GW'(idx);
        req = 1'b1;
      end
    end
  end

`ifdef HYPERBUS_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WdogCycles) + 1;

  logic [CW-1:0] wdog_q, wdog_d;
  logic          fired_q, fired_d;
  logic          wdog_hit;

  assign wdog_hit     = (wdog_q == CW'(WdogCycles - 1));
  assign wdog_fired_o = fired_q;

  always_comb begin
    wdog_d  = '0;
    fired_d = fired_q;
    if (state_q == S_WDATA || state_q == S_WRESP || state_q == S_RDATA) begin
      wdog_d = (tx_hs || rx_hs || b_hs) ? '0 : wdog_q + CW'(1);
    end
    if (state_d == S_ABRT_R || state_d == S_DRAIN || state_d == S_ABRT_B) begin
      fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      wdog_q  <= wdog_d;
      fired_q <= fired_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    write_d = write_q;
    rr_d    = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          grant_d = sel;
          write_d = port_write_i[sel];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (trans_hs) state_d = write_q ? S_WDATA : S_RDATA;
      end
      S_WDATA: begin
        if (tx_hs && port_tx_last_i[gi]) state_d = S_WRESP;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
        else if (wdog_hit) state_d = S_DRAIN;
`endif
      end
      S_WRESP: begin
        if (b_hs) state_d = S_IDLE;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
        else if (wdog_hit) state_d = S_ABRT_B;
`endif
      end
      S_RDATA: begin
        if (rx_hs && rx_last_i) state_d = S_IDLE;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
        else if (wdog_hit) state_d = S_ABRT_R;
`endif
      end
`ifdef HYPERBUS_ARB_WATCHDOG_EN
      S_ABRT_R: begin
        if (port_rx_ready_i[gi]) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (port_tx_valid_i[gi] && port_tx_last_i[gi]) state_d = S_ABRT_B;
      end
      S_ABRT_B: begin
        if (port_b_ready_i[gi]) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && state_d == S_IDLE) rr_d = rr_next;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      write_q <= write_d;
    end
  end

  // Only the granted port ever sees a ready/valid; everything idles at 0.
  always_comb begin
    port_trans_ready_o = '0;
    port_tx_ready_o    = '0;
    port_rx_data_o     = '0;
    port_rx_last_o     = 1'b0;
    port_rx_error_o    = 1'b0;
    port_rx_valid_o    = '0;
    port_b_error_o     = 1'b0;
    port_b_valid_o     = '0;
    trans_o            = '0;
    trans_write_o      = 1'b0;
    trans_valid_o      = 1'b0;
    tx_data_o          = '0;
    tx_strb_o          = '0;
    tx_last_o          = 1'b0;
    tx_valid_o         = 1'b0;
    rx_ready_o         = 1'b0;
    b_ready_o          = 1'b0;
    unique case (state_q)
      S_ISSUE: begin
        trans_o                = port_trans_i[gi*TransWidth +: TransWidth];
        trans_write_o          = write_q;
        trans_valid_o          = port_trans_valid_i[gi];
        port_trans_ready_o[gi] = trans_ready_i;
      end
      S_WDATA: begin
        tx_data_o           = port_tx_data_i[gi*DataWidth +: DataWidth];
        tx_strb_o           = port_tx_strb_i[gi*StrbWidth +: StrbWidth];
        tx_last_o           = port_tx_last_i[gi];
        tx_valid_o          = port_tx_valid_i[gi];
        port_tx_ready_o[gi] = tx_ready_i;
      end
      S_WRESP: begin
        port_b_valid_o[gi] = b_valid_i;
        port_b_error_o     = b_error_i;
        b_ready_o          = port_b_ready_i[gi];
      end
      S_RDATA: begin
        port_rx_data_o      = rx_data_i;
        port_rx_last_o      = rx_last_i;
        port_rx_error_o     = rx_error_i;
        port_rx_valid_o[gi] = rx_valid_i;
        rx_ready_o          = port_rx_ready_i[gi];
      end
`ifdef HYPERBUS_ARB_WATCHDOG_EN
      S_ABRT_R: begin
        port_rx_last_o      = 1'b1;
        port_rx_error_o     = 1'b1;
        port_rx_valid_o[gi] = 1'b1;
      end
      S_DRAIN: begin
        port_tx_ready_o[gi] = 1'b1;
      end
      S_ABRT_B: begin
        port_b_valid_o[gi] = 1'b1;
        port_b_error_o     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy_o  = (state_q != S_IDLE);
  assign grant_o = grant_q;

endmodule

// File: tb/tb_hyperbus_port_arbiter.sv
// tb_hyperbus_port_arbiter: directed stimulus, queue scoreboard with decoupled monitors.
// Watchdog scenario is compiled in with HYPERBUS_ARB_WATCHDOG_EN.
module tb_hyperbus_port_arbiter;

  localparam int NP = 4;
  localparam int TW = 48;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int WD = 16;
  localparam int TO = 200;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP*TW-1:0]  port_trans_i = '0;
  logic [NP-1:0]     port_write_i = '0;
  logic [NP-1:0]     port_trans_valid_i = '0;
  logic [NP-1:0]     port_trans_ready_o;
  logic [NP*DW-1:0]  port_tx_data_i = '0;
  logic [NP*SW-1:0]  port_tx_strb_i = '0;
  logic [NP-1:0]     port_tx_last_i = '0;
  logic [NP-1:0]     port_tx_valid_i = '0;
  logic [NP-1:0]     port_tx_ready_o;
  logic [DW-1:0]     port_rx_data_o;
  logic              port_rx_last_o;
  logic              port_rx_error_o;
  logic [NP-1:0]     port_rx_valid_o;
  logic [NP-1:0]     port_rx_ready_i = '1;
  logic              port_b_error_o;
  logic [NP-1:0]     port_b_valid_o;
  logic [NP-1:0]     port_b_ready_i = '1;
  logic [TW-1:0]     trans_o;
  logic              trans_write_o;
  logic              trans_valid_o;
  logic              trans_ready_i = 1'b1;
  logic [DW-1:0]     tx_data_o;
  logic [SW-1:0]     tx_strb_o;
  logic              tx_last_o;
  logic              tx_valid_o;
  logic              tx_ready_i = 1'b1;
  logic [DW-1:0]     rx_data_i = '0;
  logic              rx_last_i = 1'b0;
  logic              rx_error_i = 1'b0;
  logic              rx_valid_i = 1'b0;
  logic              rx_ready_o;
  logic              b_error_i = 1'b0;
  logic              b_valid_i = 1'b0;
  logic              b_ready_o;
  logic              busy_o;
  logic [1:0]        grant_o;
`ifdef HYPERBUS_ARB_WATCHDOG_EN
  logic              wdog_fired_o;
`endif

  int checks = 0;
  int fails  = 0;

  typedef struct { int p; logic [TW-1:0] d; logic w; } trans_t;
  typedef struct { logic [DW-1:0] d; logic [SW-1:0] s; logic l; } tx_t;
  typedef struct { int p; logic [DW-1:0] d; logic l; logic e; } rx_t;
  typedef struct { int p; logic e; } b_t;

  trans_t q_trans[$];
  tx_t    q_tx[$];
  rx_t    q_rx[$];
  b_t     q_b[$];

  hyperbus_port_arbiter #(
    .NumPorts(NP), .TransWidth(TW), .DataWidth(DW),
    .StrbWidth(SW), .WdogCycles(WD)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .port_trans_i(port_trans_i), .port_write_i(port_write_i),
    .port_trans_valid_i(port_trans_valid_i), .port_trans_ready_o(port_trans_ready_o),
    .port_tx_data_i(port_tx_data_i), .port_tx_strb_i(port_tx_strb_i),
    .port_tx_last_i(port_tx_last_i), .port_tx_valid_i(port_tx_valid_i),
    .port_tx_ready_o(port_tx_ready_o),
    .port_rx_data_o(port_rx_data_o), .port_rx_last_o(port_rx_last_o),
    .port_rx_error_o(port_rx_error_o), .port_rx_valid_o(port_rx_valid_o),
    .port_rx_ready_i(port_rx_ready_i),
    .port_b_error_o(port_b_error_o), .port_b_valid_o(port_b_valid_o),
    .port_b_ready_i(port_b_ready_i),
    .trans_o(trans_o), .trans_write_o(trans_write_o),
    .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
    .tx_data_o(tx_data_o), .tx_strb_o(tx_strb_o), .tx_last_o(tx_last_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_last_i(rx_last_i), .rx_error_i(rx_error_i),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .b_error_i(b_error_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
`ifdef HYPERBUS_ARB_WATCHDOG_EN
    .wdog_fired_o(wdog_fired_o),
`endif
    .busy_o(busy_o), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    fails++;
    $display("FAIL %s: got no handshake expected one within %0d cycles", nm, TO);
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    checks++;
    fails++;
    $display("FAIL %s: got event %0h expected none queued", nm, act);
  endtask

  task automatic mon_trans();
    trans_t e;
    forever begin
      @(negedge clk);
      if (!rst && trans_valid_o && trans_ready_i) begin
        if (q_trans.size() == 0) unexpected("trans_unexp", trans_o);
        else begin
          e = q_trans.pop_front();
          chk("trans_grant", grant_o, e.p);
          chk("trans_data", trans_o, e.d);
          chk("trans_write", trans_write_o, e.w);
          chk("trans_ready_onehot", port_trans_ready_o, 64'(1) << e.p);
        end
      end
    end
  endtask

  task automatic mon_tx();
    tx_t e;
    forever begin
      @(negedge clk);
      if (!rst && tx_valid_o && tx_ready_i) begin
        if (q_tx.size() == 0) unexpected("tx_unexp", tx_data_o);
        else begin
          e = q_tx.pop_front();
          chk("tx_data", tx_data_o, e.d);
          chk("tx_strb", tx_strb_o, e.s);
          chk("tx_last", tx_last_o, e.l);
        end
      end
    end
  endtask

  task automatic mon_rx();
    rx_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_valid_i && port_rx_valid_o != '0 && q_rx.size() > 0)
          chk("rx_ready_mirror", rx_ready_o, port_rx_ready_i[q_rx[0].p]);
        if ((port_rx_valid_o & port_rx_ready_i) != '0) begin
          if (q_rx.size() == 0) unexpected("rx_unexp", port_rx_valid_o);
          else begin
            e = q_rx.pop_front();
            chk("rx_valid_onehot", port_rx_valid_o, 64'(1) << e.p);
            chk("rx_data", port_rx_data_o, e.d);
            chk("rx_last", port_rx_last_o, e.l);
            chk("rx_error", port_rx_error_o, e.e);
          end
        end
      end
    end
  endtask

  task automatic mon_b();
    b_t e;
    forever begin
      @(negedge clk);
      if (!rst && (port_b_valid_o & port_b_ready_i) != '0) begin
        if (q_b.size() == 0) unexpected("b_unexp", port_b_valid_o);
        else begin
          e = q_b.pop_front();
          chk("b_valid_onehot", port_b_valid_o, 64'(1) << e.p);
          chk("b_error", port_b_error_o, e.e);
          chk("b_busy", busy_o, 1);
        end
      end
    end
  endtask

  task automatic issue(input int p, input logic [TW-1:0] d, input logic w);
    int n;
    @(posedge clk); #1;
    port_trans_i[p*TW +: TW] = d;
    port_write_i[p] = w;
    port_trans_valid_i[p] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!port_trans_ready_o[p] && n < TO);
    if (!port_trans_ready_o[p]) timeout("issue_wait");
    @(posedge clk); #1;
    port_trans_valid_i[p] = 1'b0;
  endtask

  task automatic port_tx(input int p, input int nb, input int tot,
                         input logic [DW-1:0] base, input logic [SW-1:0] s);
    int n;
    for (int k = 0; k < nb; k++) begin
      @(posedge clk); #1;
      port_tx_data_i[p*DW +: DW] = base + DW'(k);
      port_tx_strb_i[p*SW +: SW] = s;
      port_tx_last_i[p] = (k == tot - 1);
      port_tx_valid_i[p] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!port_tx_ready_o[p] && n < TO);
      if (!port_tx_ready_o[p]) begin
        timeout("tx_wait");
        break;
      end
    end
    @(posedge clk); #1;
    port_tx_valid_i[p] = 1'b0;
    port_tx_last_i[p] = 1'b0;
  endtask

  task automatic phy_rx(input int nb, input logic [DW-1:0] base, input logic err);
    int n;
    for (int k = 0; k < nb; k++) begin
      @(posedge clk); #1;
      rx_data_i  = base + DW'(k);
      rx_last_i  = (k == nb - 1);
      rx_error_i = err && (k == nb - 1);
      rx_valid_i = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!rx_ready_o && n < TO);
      if (!rx_ready_o) begin
        timeout("rx_wait");
        break;
      end
    end
    @(posedge clk); #1;
    rx_valid_i = 1'b0;
    rx_last_i  = 1'b0;
    rx_error_i = 1'b0;
  endtask

  task automatic phy_b(input logic err);
    int n;
    @(posedge clk); #1;
    b_valid_i = 1'b1;
    b_error_i = err;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!b_ready_o && n < TO);
    if (!b_ready_o) timeout("b_wait");
    @(posedge clk); #1;
    b_valid_i = 1'b0;
    b_error_i = 1'b0;
  endtask

  task automatic push_trans(input int p, input logic [TW-1:0] d, input logic w);
    trans_t e;
    e.p = p; e.d = d; e.w = w;
    q_trans.push_back(e);
  endtask

  task automatic push_rx(input int p, input logic [DW-1:0] d, input logic l, input logic er);
    rx_t e;
    e.p = p; e.d = d; e.l = l; e.e = er;
    q_rx.push_back(e);
  endtask

  task automatic push_tx(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
    tx_t e;
    e.d = d; e.s = s; e.l = l;
    q_tx.push_back(e);
  endtask

  task automatic push_b(input int p, input logic er);
    b_t e;
    e.p = p; e.e = er;
    q_b.push_back(e);
  endtask

  logic rd_done;

  initial begin
    fork
      mon_trans();
      mon_tx();
      mon_rx();
      mon_b();
      begin
        #400000;
        $display("FAIL global_timeout: got no end expected finish");
        $fatal(1);
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_trans_valid", trans_valid_o, 0);
    chk("rst_port_readies", {port_trans_ready_o, port_tx_ready_o}, 0);
    chk("rst_phy_readies", {rx_ready_o, b_ready_o, tx_valid_o}, 0);
    chk("rst_port_valids", {port_rx_valid_o, port_b_valid_o}, 0);
    chk("rst_data", {trans_o, tx_data_o[15:0]}, 0);
`ifdef HYPERBUS_ARB_WATCHDOG_EN
    chk("rst_wdog_fired", wdog_fired_o, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Ports 0 and 1 read together: 0 first, then 1
    push_trans(0, 48'h0000_1000_00A0, 1'b0);
    push_trans(1, 48'h0000_2000_00B1, 1'b0);
    push_rx(0, 32'hA000_0000, 1'b1, 1'b0);
    push_rx(1, 32'hB000_0000, 1'b1, 1'b0);
    fork
      issue(0, 48'h0000_1000_00A0, 1'b0);
      issue(1, 48'h0000_2000_00B1, 1'b0);
      begin
        phy_rx(1, 32'hA000_0000, 1'b0);
        phy_rx(1, 32'hB000_0000, 1'b0);
      end
    join

    // Port 2 writes 4 beats
    push_trans(2, 48'h0000_3000_0C02, 1'b1);
    for (int k = 0; k < 4; k++) push_tx(32'hC0DE_0000 + DW'(k), 4'hF, k == 3);
    push_b(2, 1'b0);
    fork
      issue(2, 48'h0000_3000_0C02, 1'b1);
      port_tx(2, 4, 4, 32'hC0DE_0000, 4'hF);
      phy_b(1'b0);
    join
    @(negedge clk);
    chk("wr_busy_fall", busy_o, 0);

    // Pointer now 3: ports 0 and 3 together wrap as 3 then 0
    push_trans(3, 48'h0000_4000_0D03, 1'b0);
    push_trans(0, 48'h0000_5000_0E00, 1'b0);
    push_rx(3, 32'hD000_0003, 1'b1, 1'b0);
    push_rx(0, 32'hE000_0000, 1'b1, 1'b0);
    fork
      issue(3, 48'h0000_4000_0D03, 1'b0);
      issue(0, 48'h0000_5000_0E00, 1'b0);
      begin
        phy_rx(1, 32'hD000_0003, 1'b0);
        phy_rx(1, 32'hE000_0000, 1'b0);
      end
    join

    // Port 1 reads 3 beats with its ready toggling
    push_trans(1, 48'h0000_6000_0F01, 1'b0);
    for (int k = 0; k < 3; k++) push_rx(1, 32'hF100_0000 + DW'(k), k == 2, 1'b0);
    rd_done = 1'b0;
    fork
      issue(1, 48'h0000_6000_0F01, 1'b0);
      begin
        phy_rx(3, 32'hF100_0000, 1'b0);
        rd_done = 1'b1;
      end
      begin
        for (int k = 0; k < TO && !rd_done; k++) begin
          @(posedge clk); #1;
          port_rx_ready_i[1] = (k % 2 == 0);
        end
        port_rx_ready_i[1] = 1'b1;
      end
    join

    // Port 0 re-requests while port 1 asks once: 0,1,0
    push_trans(0, 48'h0000_7000_0100, 1'b0);
    push_trans(1, 48'h0000_7000_0201, 1'b0);
    push_trans(0, 48'h0000_7000_0300, 1'b0);
    push_rx(0, 32'h7100_0000, 1'b1, 1'b0);
    push_rx(1, 32'h7200_0000, 1'b1, 1'b0);
    push_rx(0, 32'h7300_0000, 1'b1, 1'b0);
    fork
      begin
        issue(0, 48'h0000_7000_0100, 1'b0);
        issue(0, 48'h0000_7000_0300, 1'b0);
      end
      issue(1, 48'h0000_7000_0201, 1'b0);
      begin
        phy_rx(1, 32'h7100_0000, 1'b0);
        phy_rx(1, 32'h7200_0000, 1'b0);
        phy_rx(1, 32'h7300_0000, 1'b0);
      end
    join

    // Reset in WDATA after beat 2 of 4
    push_trans(1, 48'h0000_8000_0801, 1'b1);
    push_tx(32'h8800_0000, 4'h3, 1'b0);
    push_tx(32'h8800_0001, 4'h3, 1'b0);
    fork
      issue(1, 48'h0000_8000_0801, 1'b1);
      port_tx(1, 2, 4, 32'h8800_0000, 4'h3);
    join
    port_tx_data_i[1*DW +: DW] = 32'h8800_0002;
    port_tx_valid_i[1] = 1'b1;
    b_valid_i = 1'b1;
    #1;
    chk("pre_rst_tx_valid", tx_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_tx", {tx_valid_o, port_tx_ready_o}, 0);
    chk("mid_rst_trans", {trans_valid_o, port_trans_ready_o}, 0);
    chk("mid_rst_rxb", {rx_ready_o, b_ready_o, port_rx_valid_o, port_b_valid_o}, 0);
    chk("mid_rst_data", tx_data_o, 0);
    port_tx_valid_i = '0;
    port_tx_last_i  = '0;
    b_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset: pointer back at 0, so 0 (write, B error) then 1 (read, error)
    push_trans(0, 48'h0000_9000_0900, 1'b1);
    push_trans(1, 48'h0000_9000_0A01, 1'b0);
    push_tx(32'h9900_0000, 4'h5, 1'b1);
    push_b(0, 1'b1);
    push_rx(1, 32'h9A00_0000, 1'b0, 1'b0);
    push_rx(1, 32'h9A00_0001, 1'b1, 1'b1);
    fork
      issue(0, 48'h0000_9000_0900, 1'b1);
      issue(1, 48'h0000_9000_0A01, 1'b0);
      port_tx(0, 1, 1, 32'h9900_0000, 4'h5);
      phy_b(1'b1);
      phy_rx(2, 32'h9A00_0000, 1'b1);
    join
    @(negedge clk);
    chk("post_rst_idle", busy_o, 0);

`ifdef HYPERBUS_ARB_WATCHDOG_EN
    // Read on port 3 with no PHY data: abort after WD cycles
    begin
      int n;
      chk("wdog_clear_before", wdog_fired_o, 0);
      push_trans(3, 48'h0000_A000_0B03, 1'b0);
      push_rx(3, 32'h0, 1'b1, 1'b1);
      issue(3, 48'h0000_A000_0B03, 1'b0);
      n = 0;
      do begin
        @(negedge clk);
        if (port_rx_valid_o[3]) break;
        n++;
      end while (n < TO);
      chk("wdog_latency", n, WD);
      chk("wdog_fired", wdog_fired_o, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("wdog_idle", busy_o, 0);
    end
`endif

    repeat (3) @(negedge clk);
    chk("q_trans_left", q_trans.size(), 0);
    chk("q_tx_left", q_tx.size(), 0);
    chk("q_rx_left", q_rx.size(), 0);
    chk("q_b_left", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
